fpu_issue_stage: RTL and testbench
==================================

FPU_ISSUE_STAGE -- requirements
Module: fpu_issue_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 2, operand FIFO depth (power of two, >=2).
REQ-002 SHALL have parameter TAGW, default 4, request tag width.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  request accepted when high with in_valid.
REQ-008 in_op  input  1  0 = multiply, 1 = divide.
REQ-009 in_a / in_b  input  32 each  IEEE-754 single operands.
REQ-010 in_tag  input  TAGW  opaque request tag.
REQ-011 op_a / op_b  output  32 each  stage-1 operands; drive the external fp_mul and fp_div A/B inputs.
REQ-012 res_mul / res_div  input  32 each  combinational results returned by fp_mul / fp_div.
REQ-013 out_valid  output  1  result present.
REQ-014 out_ready  input  1  downstream accepts the result.
REQ-015 out_result  output  32  selected result.
REQ-016 out_tag  output  TAGW  tag of out_result.
REQ-017 out_flags  output  4  [3] invalid (NaN), [2] divzero, [1] inf, [0] zero.
REQ-018 fill  output  clog2(DEPTH)+1  FIFO occupancy.
REQ-019 busy  output  1  FIFO non-empty, or s1_valid, or out_valid.
REQ-020 done_count  output  16  completed output handshakes.

Function
REQ-021 SHALL push {op, tag, a, b} into the FIFO on in_valid && in_ready; in_ready = (fill < DEPTH), with no same-cycle bypass when full.
REQ-022 SHALL define s1_adv = s1_valid && (!out_valid || out_ready).
REQ-023 SHALL load the stage-1 register from the FIFO head, with a pop, when the FIFO is non-empty and (!s1_valid || s1_adv).
REQ-024 SHALL drive op_a/op_b from stage-1 and hold them stable while s1_valid && !s1_adv.
REQ-025 On s1_adv SHALL load out_result = (s1_op ? res_div : res_mul) and load out_tag, out_flags, and out_valid = 1.
REQ-026 SHALL clear out_valid on an out_valid && out_ready handshake with no simultaneous s1_adv.
REQ-027 SHALL hold out_result/tag/flags stable while out_valid && !out_ready.
REQ-028 Latency: request accepted in cycle 0 into an empty pipe produces out_valid in cycle 2; throughput is 1 per cycle with out_ready held high.
REQ-029 Flags from out_result:
- invalid = exponent 0xFF and mantissa != 0.
- inf = exponent 0xFF and mantissa == 0.
- zero = result[30:0] == 0.
REQ-030 Flag divzero SHALL be set when s1_op = 1, s1_b[30:0] == 0, and s1_a is finite and non-zero.
REQ-031 Push and pop in the same cycle SHALL leave fill unchanged; FIFO pointers wrap modulo DEPTH.
REQ-032 done_count SHALL increment on each output handshake and wrap from 0xFFFF to 0x0000.
REQ-033 Order SHALL be preserved: outputs leave in acceptance order.

Reset
REQ-034 On rst SHALL force the following to 0: in_ready, FIFO pointers, fill, s1_valid, out_valid, out_result, out_tag, out_flags, done_count.
REQ-035 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-036 Reset mid-operation SHALL discard all in-flight entries.
REQ-037 A reset cycle SHALL neither count a handshake nor accept a push.

Structure
REQ-038 Package fpu_pkg SHALL hold:
- constants NAN 0x7FC00000, INF 0x7F800000, ZERO 0x00000000;
- OP_MUL/OP_DIV encodings;
- flag bit indices;
- the FIFO entry width.
REQ-039 A sub-module fpu_issue_fifo (synchronous FIFO: DEPTH, width, push/pop, fill) SHALL be instantiated once.
REQ-040 fp_mul and fp_div SHALL remain outside this block.

Verification
REQ-041 Mul 0x40000000 * 0x40400000, tag 3, out_ready=1 -> cycle 2: out_result 0x40C00000, out_tag 3, flags 0000.
REQ-042 Div 0x3F800000 / 0x00000000 -> out_result 0x7F800000, flags 0110 (divzero, inf).
REQ-043 out_ready=0 with DEPTH=2 and continuous requests -> exactly 4 accepted, then in_ready=0 and fill=2; release out_ready -> 4 results in tag order, one per cycle.
REQ-044 Mul 0x7F800000 * 0x00000000 -> out_result 0x7FC00000, flags 1000.
REQ-045 rst asserted with 3 ops in flight -> next cycle out_valid=0, fill=0, done_count=0, in_ready=1, and no stale output later.
REQ-046 Preload done_count to 0xFFFF via 65535 handshakes, then one more handshake -> done_count 0x0000.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared constants and helpers for the FPU issue stage.
//   - canonical single-precision constants (NAN, INF, ZERO)
//   - operation encoding (OP_MUL / OP_DIV)
//   - out_flags bit indices
//   - FIFO entry width {op, tag, a, b} and a result-flag helper
package fpu_pkg;

  localparam logic [31:0] NAN  = 32'h7FC0_0000;
  localparam logic [31:0] INF  = 32'h7F80_0000;
  localparam logic [31:0] ZERO = 32'h0000_0000;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } fpu_op_e;

  localparam int FLAG_INVALID = 3;
  localparam int FLAG_DIVZERO = 2;
  localparam int FLAG_INF     = 1;
  localparam int FLAG_ZERO    = 0;

  localparam int OPERAND_W = 32;

  // FIFO entry layout, MSB first: op | tag | a | b
  function automatic int entry_width(input int tagw);
    return 1 + tagw + 2 * OPERAND_W;
  endfunction

  localparam int ENTRY_W = entry_width(4);

  // Classify a result; divzero is decided from the operands by the caller.
  function automatic logic [3:0] result_flags(input logic [31:0] r, input logic divzero);
    logic [3:0] f;
    f = 4'b0000;
    f[FLAG_INVALID] = (r[30:23] == 8'hFF) && (r[22:0] != 23'd0);
    f[FLAG_INF]     = (r[30:23] == 8'hFF) && (r[22:0] == 23'd0);
    f[FLAG_ZERO]    = (r[30:0] == 31'd0);
    f[FLAG_DIVZERO] = divzero;
    return f;
  endfunction

endpackage

// File: rtl/fpu_issue_fifo.sv
// fpu_issue_fifo: synchronous FIFO holding accepted FPU requests.
//   clk, rst        : clock, synchronous active-high reset
//   push, push_data : write one entry (ignored when full)
//   pop, pop_data   : remove head entry (ignored when empty); pop_data shows head
//   full, empty     : occupancy status
//   fill            : occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module fpu_issue_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];
  assign fill     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read when counted valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fpu_issue_stage.sv
// fpu_issue_stage: buffers multiply/divide requests, presents operands to
// external fp_mul / fp_div units from a stage-1 register, and captures the
// selected result with flags into a valid/ready output register.
//   clk, rst                          : clock, synchronous active-high reset
//   in_valid/in_ready, in_op, in_a,
//   in_b, in_tag                      : request handshake and payload
//   op_a, op_b                        : operands to fp_mul and fp_div
//   res_mul, res_div                  : combinational results from those units
//   out_valid/out_ready, out_result,
//   out_tag, out_flags                : result handshake and payload
//   fill                              : FIFO occupancy
//   busy                              : any request still in the block
//   done_count                        : completed output handshakes (wraps)
module fpu_issue_stage
  import fpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAGW  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_op,
  input  logic [31:0]            in_a,
  input  logic [31:0]            in_b,
  input  logic [TAGW-1:0]        in_tag,
  output logic [31:0]            op_a,
  output logic [31:0]            op_b,
  input  logic [31:0]            res_mul,
  input  logic [31:0]            res_div,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_result,
  output logic [TAGW-1:0]        out_tag,
  output logic [3:0]             out_flags,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   busy,
  output logic [15:0]            done_count
);

  localparam int EW = entry_width(TAGW);

  logic [EW-1:0] push_entry, head;
  logic          fifo_full, fifo_empty;
  logic          push, pop;

  logic            s1_valid_q, s1_valid_d;
  logic            s1_op_q, s1_op_d;
  logic [TAGW-1:0] s1_tag_q, s1_tag_d;
  logic [31:0]     s1_a_q, s1_a_d;
  logic [31:0]     s1_b_q, s1_b_d;

  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_result_q, out_result_d;
  logic [TAGW-1:0] out_tag_q, out_tag_d;
  logic [3:0]      out_flags_q, out_flags_d;
  logic [15:0]     done_count_q, done_count_d;

  logic        s1_adv;
  logic        out_hs;
  logic [31:0] sel_result;
  logic        divzero;

  // Held low during reset so the reset cycle can never accept a push.
  assign in_ready   = !rst && !fifo_full;
  assign push       = in_valid && in_ready;
  assign push_entry = {in_op, in_tag, in_a, in_b};

  fpu_issue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .fill      (fill)
  );

  assign s1_adv = s1_valid_q && (!out_valid_q || out_ready);
  assign pop    = !fifo_empty && (!s1_valid_q || s1_adv);
  assign out_hs = out_valid_q && out_ready;

  assign sel_result = (s1_op_q == OP_DIV) ? res_div : res_mul;
  // Division of a finite non-zero dividend by +/-0.
  assign divzero = (s1_op_q == OP_DIV) && (s1_b_q[30:0] == 31'd0) &&
                   (s1_a_q[30:23] != 8'hFF) && (s1_a_q[30:0] != 31'd0);

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_tag_d   = s1_tag_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (pop) begin
      s1_valid_d = 1'b1;
      s1_op_d    = head[EW-1];
      s1_tag_d   = head[EW-2 -: TAGW];
      s1_a_d     = head[63:32];
      s1_b_d     = head[31:0];
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    out_flags_d  = out_flags_q;
    done_count_d = done_count_q;
    if (s1_adv) begin
      out_valid_d  = 1'b1;
      out_result_d = sel_result;
      out_tag_d    = s1_tag_q;
      out_flags_d  = result_flags(sel_result, divzero);
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end
    if (out_hs) done_count_d = done_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= 1'b0;
      s1_tag_q     <= '0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      out_flags_q  <= '0;
      done_count_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_op_q      <= s1_op_d;
      s1_tag_q     <= s1_tag_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
      out_flags_q  <= out_flags_d;
      done_count_q <= done_count_d;
    end
  end

  assign op_a       = s1_a_q;
  assign op_b       = s1_b_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;
  assign out_flags  = out_flags_q;
  assign done_count = done_count_q;
  assign busy       = !fifo_empty || s1_valid_q || out_valid_q;

endmodule

// File: tb/tb_fpu_issue_stage.sv
// tb_fpu_issue_stage: randomized and directed checks of fpu_issue_stage.
// Stand-in fp_mul/fp_div units are pure functions of their operands, so the
// expected result of every request is known at acceptance and kept in an
// in-order scoreboard.
module tb_fpu_issue_stage;
  import fpu_pkg::*;

  localparam int DEPTH = 2;
  localparam int TAGW  = 4;
  localparam int FW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            in_op = 1'b0;
  logic [31:0]     in_a = '0, in_b = '0;
  logic [TAGW-1:0] in_tag = '0;
  logic [31:0]     op_a, op_b, res_mul, res_div;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [31:0]     out_result;
  logic [TAGW-1:0] out_tag;
  logic [3:0]      out_flags;
  logic [FW-1:0]   fill;
  logic            busy;
  logic [15:0]     done_count;

  always #5 clk = ~clk;

  fpu_issue_stage #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .op_a(op_a), .op_b(op_b), .res_mul(res_mul), .res_div(res_div),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_flags(out_flags),
    .fill(fill), .busy(busy), .done_count(done_count)
  );

  // Stand-in arithmetic units: exact answers for the directed vectors,
  // otherwise a scrambled value that often lands on NaN / Inf / zero.
  function automatic logic [31:0] fake_res(input logic op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x;
    if (!op && a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    if (!op && a == INF && b == ZERO) return NAN;
    if (op && a == 32'h3F80_0000 && b == ZERO) return INF;
    x = (a * 32'd31) ^ {b[15:0], b[31:16]} ^ (op ? 32'h5A5A_1234 : 32'h0);
    case (x[3:0])
      4'd0:    return {x[31], 8'hFF, 23'd0};
      4'd1:    return {x[31], 8'hFF, x[22:1], 1'b1};
      4'd2:    return {x[31], 31'd0};
      default: return x;
    endcase
  endfunction

  assign res_mul = fake_res(1'b0, op_a, op_b);
  assign res_div = fake_res(1'b1, op_a, op_b);

  function automatic logic [3:0] exp_flags(input logic op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] r);
    logic nan_r, inf_r, zero_r, dz;
    nan_r  = (r[30:23] == 8'hFF) && (r[22:0] != 0);
    inf_r  = (r[30:23] == 8'hFF) && (r[22:0] == 0);
    zero_r = (r[30:0] == 0);
    dz     = op && (b[30:0] == 0) && (a[30:23] != 8'hFF) && (a[30:0] != 0);
    return {nan_r, dz, inf_r, zero_r};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom % 7)
      0:       return ZERO;
      1:       return INF;
      2:       return NAN;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  typedef struct packed {
    logic [31:0]     res;
    logic [TAGW-1:0] tag;
    logic [3:0]      flags;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] done_m = '0;
  int          accepted = 0;
  int          hs_total = 0;
  int          n_cmp = 0;
  int          n_mis = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Observe the cycle's handshakes; called mid-cycle while inputs are stable.
  task automatic monitor();
    exp_t e;
    if (rst) return;
    chk("done_count", done_count, done_m);
    if (out_valid) begin
      chk("out_has_request", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        chk("out_result", out_result, sb[0].res);
        chk("out_tag", out_tag, sb[0].tag);
        chk("out_flags", out_flags, sb[0].flags);
      end
      if (out_ready) begin
        if (sb.size() > 0) void'(sb.pop_front());
        done_m++;
        hs_total++;
      end
    end
    if (in_valid && in_ready) begin
      e.res   = fake_res(in_op, in_a, in_b);
      e.tag   = in_tag;
      e.flags = exp_flags(in_op, in_a, in_b, e.res);
      sb.push_back(e);
      accepted++;
    end
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic finish_cycle();
    monitor();
    @(negedge clk);
  endtask

  task automatic tick();
    settle();
    finish_cycle();
  endtask

  task automatic drive_req(input logic op, input logic [31:0] a, input logic [31:0] b, input logic [TAGW-1:0] tag);
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    in_tag = tag;
  endtask

  task automatic drain(input string name);
    int n;
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((sb.size() > 0 || out_valid) && n < 50) begin
      tick();
      n++;
    end
    chk(name, sb.size(), 0);
  endtask

  task automatic directed(input string name, input logic op, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAGW-1:0] tag, input logic [31:0] want_r, input logic [3:0] want_f);
    int n;
    out_ready = 1'b1;
    drive_req(op, a, b, tag);
    tick();
    in_valid = 1'b0;
    n = 0;
    settle();
    while (!out_valid && n < 10) begin
      finish_cycle();
      settle();
      n++;
    end
    chk({name, "_seen"}, out_valid, 1);
    chk({name, "_result"}, out_result, want_r);
    chk({name, "_flags"}, out_flags, want_f);
    chk({name, "_tag"}, out_tag, tag);
    finish_cycle();
    drain({name, "_drain"});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    settle();
    chk("rst_in_ready", in_ready, 0);
    finish_cycle();
    rst = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    done_m = '0;
    hs_total = 0;
    settle();
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_fill", fill, 0);
    chk("post_rst_done", done_count, 0);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_busy", busy, 0);
    finish_cycle();
  endtask

  initial begin
    int base;
    int n;

    do_reset();

    // Latency from an empty pipe: out_valid rises on the second rising
    // edge after the edge that accepted the request.
    out_ready = 1'b1;
    drive_req(OP_MUL, 32'h4000_0000, 32'h4040_0000, 4'd3);
    settle();
    chk("lat_accept", in_ready, 1);
    finish_cycle();
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      settle();
      chk($sformatf("lat_valid_%0d", k), out_valid, (k == 3));
      if (k == 3) begin
        chk("mul_result", out_result, 32'h40C0_0000);
        chk("mul_tag", out_tag, 3);
        chk("mul_flags", out_flags, 4'b0000);
        chk("busy_active", busy, 1);
      end
      finish_cycle();
    end
    drain("lat_drain");

    directed("div0", OP_DIV, 32'h3F80_0000, ZERO, 4'd5, INF, 4'b0110);
    directed("inf0", OP_MUL, INF, ZERO, 4'd9, NAN, 4'b1000);

    // Backpressure: with the output stalled only DEPTH+2 requests fit.
    out_ready = 1'b0;
    base = accepted;
    for (int i = 0; i < 8; i++) begin
      drive_req(OP_MUL, pick_operand(), pick_operand(), TAGW'(accepted));
      tick();
    end
    settle();
    chk("bp_accepted", accepted - base, DEPTH + 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_fill", fill, DEPTH);
    finish_cycle();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("bp_rel_valid", out_valid, 1);
      chk("bp_rel_tag", out_tag, TAGW'(base + i));
      finish_cycle();
    end
    drain("bp_drain");

    // Random traffic with random backpressure.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom % 10) < 7;
      in_op     = $urandom % 2;
      in_a      = pick_operand();
      in_b      = pick_operand();
      in_tag    = TAGW'($urandom);
      out_ready = ($urandom % 10) < 6;
      tick();
    end
    drain("rand_drain");

    // Reset with requests in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_req(OP_DIV, pick_operand(), pick_operand(), TAGW'(i));
      tick();
    end
    in_valid = 1'b0;
    chk("inflight_before_rst", sb.size(), 3);
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    settle();
    chk("no_stale_busy", busy, 0);
    chk("no_stale_valid", out_valid, 0);
    finish_cycle();

    // done_count wrap: 65535 handshakes, then one more.
    out_ready = 1'b1;
    n = 0;
    while (hs_total + sb.size() < 65535 && n < 70000) begin
      drive_req($urandom % 2, $urandom, $urandom, TAGW'($urandom));
      tick();
      n++;
    end
    drain("wrap_drain");
    settle();
    chk("done_ffff", done_count, 16'hFFFF);
    finish_cycle();
    directed("wrap_last", OP_MUL, 32'h4000_0000, 32'h4040_0000, 4'd1, 32'h40C0_0000, 4'b0000);
    settle();
    chk("done_wrap", done_count, 16'h0000);
    finish_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
